// File: rtl/memory_unit.sv
// 16x8 flip-flop memory on a shared tri-state CPU bus (MAR/MDR access), with a
// streaming loader that fills every word from an external byte source.
module memory_unit #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [7:0]        bus,
    input  logic              nLma,
    input  logic              nLmd,
    input  logic              nCE,
    input  logic              nLr,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [7:0]        prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // One bit per non-idle state so prog_ready/prog_done are single-flop decodes.
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StLoad = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [ADDR_W-1:0] mar_q;
    logic [7:0]        mdr_q;
    logic [7:0]        mem_q [DEPTH];

    logic cpu_mode;
    logic load_we;
    logic cpu_we;

    assign cpu_mode = (state_q == StIdle);
    assign load_we  = (state_q == StLoad) && prog_mode && prog_valid;
    assign cpu_we   = cpu_mode && !nLr;

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        case (state_q)
            StIdle: begin
                if (prog_mode) begin
                    state_d     = StLoad;
                    prog_addr_d = '0;
                end
            end
            StLoad: begin
                if (!prog_mode) begin
                    state_d = StIdle;
                end else if (prog_valid) begin
                    prog_addr_d = prog_addr_q + ADDR_W'(1);
                    if (prog_addr_q == '1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!prog_mode) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prog_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else if (cpu_mode) begin
            if (!nLma) begin
                mar_q <= bus[ADDR_W-1:0];
            end
            if (!nLmd) begin
                mdr_q <= bus;
            end
        end
    end

    // Writes use pre-edge MAR/MDR, so same-edge loads of either never affect the write.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[i] <= '0;
            end else if (load_we && (prog_addr_q == ADDR_W'(i))) begin
                mem_q[i] <= prog_data;
            end else if (cpu_we && (mar_q == ADDR_W'(i))) begin
                mem_q[i] <= mdr_q;
            end
        end
    end

    assign bus        = (rst_n && cpu_mode && !nCE) ? mem_q[mar_q] : {8{1'bz}};
    assign prog_ready = state_q[0];
    assign prog_done  = state_q[1];
    assign mar_out    = mar_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: CPU access, same-edge collisions, loader, abort,
// bus isolation and asynchronous reset. Undriven bus is pulled up to 0xFF.
module tb_memory_unit;

    logic       clk;
    logic       rst_n;
    tri1  [7:0] bus;
    logic       tb_en;
    logic [7:0] tb_drv;
    logic       nLma, nLmd, nCE, nLr;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_done;
    logic [3:0] mar_out;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] Float = 8'hFF;

    assign bus = tb_en ? tb_drv : 8'hzz;

    memory_unit #(.ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .nLma       (nLma),
        .nLmd       (nLmd),
        .nCE        (nCE),
        .nLr        (nLr),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .mar_out    (mar_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load MAR from drv, then read the addressed word combinationally.
    task automatic rd(input logic [7:0] drv, input logic [7:0] exp, input string tag);
        tb_en  = 1'b1;
        tb_drv = drv;
        nLma   = 1'b0;
        step();
        nLma  = 1'b1;
        tb_en = 1'b0;
        nCE   = 1'b0;
        #1;
        check($sformatf("%s[%0d]", tag, drv[3:0]), bus, exp);
        nCE = 1'b1;
    endtask

    task automatic drive_step(input logic [7:0] v, input logic lma, input logic lmd);
        tb_en  = 1'b1;
        tb_drv = v;
        nLma   = lma;
        nLmd   = lmd;
        step();
        nLma  = 1'b1;
        nLmd  = 1'b1;
        tb_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tb_en = 1'b0; tb_drv = 8'h00;
        nLma = 1'b1; nLmd = 1'b1; nCE = 1'b0; nLr = 1'b1;
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;

        // Reset state, with nCE asserted to show the bus stays released.
        #12;
        check("rst_bus", bus, Float);
        check("rst_ready", {7'd0, prog_ready}, 8'h00);
        check("rst_done", {7'd0, prog_done}, 8'h00);
        check("rst_mar", {4'd0, mar_out}, 8'h00);
        #6 rst_n = 1'b1;
        step();
        check("idle_rd0", bus, 8'h00);
        nCE = 1'b1;
        #1;
        check("idle_hiz", bus, Float);

        // Basic write then read.
        drive_step(8'h05, 1'b0, 1'b1);
        drive_step(8'hA7, 1'b1, 1'b0);
        nLr = 1'b0;
        step();
        nLr = 1'b1;
        nCE = 1'b0;
        #1;
        check("wr_rd", bus, 8'hA7);
        check("wr_mar", {4'd0, mar_out}, 8'h05);
        nCE = 1'b1;
        rd(8'h3C, 8'h00, "hi_ign");
        check("hi_ign_mar", {4'd0, mar_out}, 8'h0C);

        // MAR load and write on one edge: write lands at old MAR.
        drive_step(8'h03, 1'b0, 1'b1);
        drive_step(8'h11, 1'b1, 1'b0);
        nLr = 1'b0;
        drive_step(8'h09, 1'b0, 1'b1);
        nLr = 1'b1;
        check("col_mar", {4'd0, mar_out}, 8'h09);
        rd(8'h03, 8'h11, "col");
        rd(8'h09, 8'h00, "col");

        // MDR load and write on one edge: old MDR written; read-during-write.
        nLr = 1'b0;
        drive_step(8'h22, 1'b1, 1'b0);
        nLr = 1'b1;
        nCE = 1'b0;
        #1;
        check("old_mdr", bus, 8'h11);
        nLr = 1'b0;
        #1;
        check("rdw_same", bus, 8'h11);
        step();
        check("rdw_next", bus, 8'h22);
        nLr = 1'b1;
        nCE = 1'b1;

        // MDR captures the word this block drives.
        rd(8'h05, 8'hA7, "ce_lmd");
        nCE  = 1'b0;
        nLmd = 1'b0;
        step();
        nCE  = 1'b1;
        nLmd = 1'b1;
        drive_step(8'h04, 1'b0, 1'b1);
        nLr = 1'b0;
        step();
        nLr = 1'b1;
        rd(8'h04, 8'hA7, "ce_lmd");

        // Full load with a two-cycle valid gap before byte 7.
        prog_mode = 1'b1;
        step();
        check("ld_ready", {7'd0, prog_ready}, 8'h01);
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                prog_valid = 1'b0;
                step();
                step();
                check("ld_gap_done", {7'd0, prog_done}, 8'h00);
            end
            prog_valid = 1'b1;
            prog_data  = 8'(k);
            if (k == 15) check("ld_done_early", {7'd0, prog_done}, 8'h00);
            step();
        end
        prog_valid = 1'b0;
        check("ld_done", {7'd0, prog_done}, 8'h01);
        check("ld_done_rdy", {7'd0, prog_ready}, 8'h00);
        step();
        check("ld_done_hold", {7'd0, prog_done}, 8'h01);
        prog_mode = 1'b0;
        step();
        check("ld_exit", {6'd0, prog_done, prog_ready}, 8'h00);
        for (int k = 0; k < 16; k++) rd(8'(k), 8'(k), "ld");

        // Abort after four bytes, with isolation probes in the middle.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive_step(8'h09, 1'b0, 1'b1);
        drive_step(8'h5A, 1'b1, 1'b0);
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1;
        prog_data = 8'hF0; step();
        prog_data = 8'hF1; step();
        prog_valid = 1'b0;
        nCE = 1'b0;
        nLr = 1'b0;
        #1;
        check("iso_bus", bus, Float);
        step();
        nCE = 1'b1;
        nLr = 1'b1;
        drive_step(8'h0E, 1'b0, 1'b0);
        check("iso_mar", {4'd0, mar_out}, 8'h09);
        prog_valid = 1'b1;
        prog_data = 8'hF2; step();
        prog_data = 8'hF3; step();
        prog_mode = 1'b0;
        prog_data = 8'hEE;
        step();
        prog_valid = 1'b0;
        check("ab_ready", {7'd0, prog_ready}, 8'h00);
        nLr = 1'b0;
        step();
        nLr = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k < 4)       rd(8'(k), 8'hF0 + 8'(k), "ab");
            else if (k == 9) rd(8'(k), 8'h5A, "ab");
            else             rd(8'(k), 8'h00, "ab");
        end

        // Asynchronous reset between edges mid-load.
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1;
        prog_data  = 8'h77;
        step();
        prog_valid = 1'b0;
        check("ar_pre_ready", {7'd0, prog_ready}, 8'h01);
        #3 rst_n = 1'b0;
        nCE = 1'b0;
        #1;
        check("ar_ready", {7'd0, prog_ready}, 8'h00);
        check("ar_done", {7'd0, prog_done}, 8'h00);
        check("ar_mar", {4'd0, mar_out}, 8'h00);
        check("ar_bus", bus, Float);
        nCE = 1'b1;
        prog_mode = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) rd(8'(k), 8'h00, "ar");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
